// File: rtl/wb_commit_arbiter_if.sv
// Writeback commit bundle: pipeline wb, long-latency
// result stream, scoreboard query and regfile write port.
interface wb_commit_arbiter_if;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        wb_stall;
  logic        lr_valid;
  logic [4:0]  lr_rd;
  logic [63:0] lr_data;
  logic        lr_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        hazard;
  logic [31:0] pending;
  logic        we;
  logic [4:0]  write_addr;
  logic [63:0] write_data;

  modport slave (
    input  wb_valid, wb_rd, wb_data,
    output wb_stall,
    input  lr_valid, lr_rd, lr_data,
    output lr_ready,
    input  issue_valid, issue_rd, rs1, rs2,
    output hazard, pending,
    output we, write_addr, write_data
  );

  modport master (
    output wb_valid, wb_rd, wb_data,
    input  wb_stall,
    output lr_valid, lr_rd, lr_data,
    input  lr_ready,
    output issue_valid, issue_rd, rs1, rs2,
    input  hazard, pending,
    input  we, write_addr, write_data
  );
endinterface

// File: rtl/wb_commit_arbiter.sv
// Writeback commit stage: merges pipeline and buffered
// long-latency results onto the regfile write port.
module wb_commit_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  wb_commit_arbiter_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]    mem_rd   [DEPTH];
  logic [63:0]   mem_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;
  logic [31:0]   pend_q;
  logic [31:0]   pend_nxt;
  logic          we_q;
  logic [4:0]    addr_q;
  logic [63:0]   data_q;

  logic          lr_ready;
  logic          nonempty;
  logic          starve;
  logic          push;
  logic          pop;
  logic          sel_wb;
  logic [4:0]    head_rd;
  logic [63:0]   head_data;
  logic [4:0]    sel_rd;
  logic [63:0]   sel_data;

  always_comb begin
    lr_ready  = count < CW'(DEPTH);
    nonempty  = count != '0;
    starve    = nonempty
              & (starve_cnt >= SW'(STARVE_MAX));
    push      = bus.lr_valid & lr_ready;
    pop       = starve | (~bus.wb_valid & nonempty);
    sel_wb    = ~starve & bus.wb_valid;
    head_rd   = mem_rd[rd_ptr];
    head_data = mem_data[rd_ptr];
    sel_rd    = pop ? head_rd : bus.wb_rd;
    sel_data  = pop ? head_data : bus.wb_data;
  end

  // Set after clear so a same-cycle issue keeps the bit.
  always_comb begin
    pend_nxt = pend_q;
    if (pop && head_rd != 5'd0)
      pend_nxt[head_rd] = 1'b0;
    if (bus.issue_valid && bus.issue_rd != 5'd0)
      pend_nxt[bus.issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr]   <= bus.lr_rd;
      mem_data[wr_ptr] <= bus.lr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      pend_q     <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        push & ~pop: count <= count + 1'b1;
        pop & ~push: count <= count - 1'b1;
        default:     count <= count;
      endcase
      if (pop || !nonempty)
        starve_cnt <= '0;
      else if (sel_wb
               && starve_cnt < SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
      pend_q <= pend_nxt;
      if (pop || sel_wb) begin
        we_q   <= sel_rd != 5'd0;
        addr_q <= sel_rd;
        data_q <= sel_data;
      end else begin
        we_q <= 1'b0;
      end
    end
  end

  assign bus.lr_ready   = lr_ready;
  assign bus.wb_stall   = starve;
  assign bus.pending    = pend_q;
  assign bus.hazard     = pend_q[bus.rs1]
                        | pend_q[bus.rs2];
  assign bus.we         = we_q;
  assign bus.write_addr = addr_q;
  assign bus.write_data = data_q;
endmodule

// File: tb/tb_wb_commit_arbiter.sv
// Self-checking bench for wb_commit_arbiter against a
// queue-based reference model of the commit rules.
module tb_wb_commit_arbiter;
  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  wb_commit_arbiter_if bus();

  wb_commit_arbiter #(
    .DEPTH(DEPTH),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]  q_rd [$];
  logic [63:0] q_d  [$];
  int          m_losses;
  logic [31:0] m_pend;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [63:0] m_data;

  function automatic bit m_stall();
    return q_rd.size() != 0 && m_losses >= SMAX;
  endfunction

  function automatic bit m_ready();
    return q_rd.size() < DEPTH;
  endfunction

  function automatic bit m_hazard();
    return m_pend[bus.rs1] | m_pend[bus.rs2];
  endfunction

  task automatic model_reset();
    q_rd.delete();
    q_d.delete();
    m_losses = 0;
    m_pend   = '0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_data   = '0;
  endtask

  task automatic model_step();
    int          n;
    bit          from_q;
    bit          from_wb;
    logic [4:0]  rd;
    logic [63:0] d;
    n       = q_rd.size();
    from_q  = m_stall() || (!bus.wb_valid && n != 0);
    from_wb = !from_q && bus.wb_valid;
    rd      = bus.wb_rd;
    d       = bus.wb_data;
    if (from_q) begin
      rd = q_rd.pop_front();
      d  = q_d.pop_front();
    end
    if (bus.lr_valid && n < DEPTH) begin
      q_rd.push_back(bus.lr_rd);
      q_d.push_back(bus.lr_data);
    end
    if (from_q || from_wb) begin
      m_we   = rd != 0;
      m_addr = rd;
      m_data = d;
    end else begin
      m_we = 1'b0;
    end
    if (from_q || n == 0) m_losses = 0;
    else if (from_wb && m_losses < SMAX)
      m_losses++;
    if (from_q && rd != 0) m_pend[rd] = 1'b0;
    if (bus.issue_valid && bus.issue_rd != 0)
      m_pend[bus.issue_rd] = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    bus.wb_valid    = 1'b0;
    bus.lr_valid    = 1'b0;
    bus.issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.wb_rd = '0;  bus.wb_data = '0;
    bus.lr_rd = '0;  bus.lr_data = '0;
    bus.issue_rd = '0;
    bus.rs1 = '0;    bus.rs2 = '0;
    idle();
    model_reset();
    #12;
    total_cnt++;
    if (bus.we !== 1'b0)
      $display("FAIL reset_we act=%b exp=0", bus.we);
    else pass_cnt++;
    total_cnt++;
    if (bus.write_addr !== 5'd0 || bus.write_data !== 64'd0)
      $display("FAIL reset_wr act=%0d/%h exp=0/0",
               bus.write_addr, bus.write_data);
    else pass_cnt++;
    total_cnt++;
    if (bus.pending !== 32'd0 || bus.hazard !== 1'b0)
      $display("FAIL reset_pend act=%h/%b exp=0/0",
               bus.pending, bus.hazard);
    else pass_cnt++;
    total_cnt++;
    if (bus.lr_ready !== 1'b1 || bus.wb_stall !== 1'b0)
      $display("FAIL reset_hs act=%b/%b exp=1/0",
               bus.lr_ready, bus.wb_stall);
    else pass_cnt++;
    rst = 1'b1;
  endtask

  task automatic test_single_wb();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    bus.wb_data  = 64'h1234;
    tick();
    total_cnt++;
    if (bus.we !== 1'b1 || bus.write_addr !== 5'd5
        || bus.write_data !== 64'h1234)
      $display("FAIL wb_single act=%b/%0d/%h exp=1/5/1234",
               bus.we, bus.write_addr, bus.write_data);
    else pass_cnt++;
    idle();
    tick();
    total_cnt++;
    if (bus.we !== 1'b0)
      $display("FAIL wb_single_off act=%b exp=0", bus.we);
    else pass_cnt++;
  endtask

  task automatic test_lr_basic();
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd7;
    tick();
    bus.issue_valid = 1'b0;
    bus.rs1 = 5'd7;
    bus.rs2 = 5'd0;
    bus.lr_valid = 1'b1;
    bus.lr_rd    = 5'd7;
    bus.lr_data  = 64'hDEAD;
    #1;
    total_cnt++;
    if (bus.pending[7] !== 1'b1 || bus.hazard !== 1'b1)
      $display("FAIL lr_pend_set act=%b/%b exp=1/1",
               bus.pending[7], bus.hazard);
    else pass_cnt++;
    tick();
    bus.lr_valid = 1'b0;
    #1;
    total_cnt++;
    if (bus.we !== 1'b0 || bus.hazard !== 1'b1)
      $display("FAIL lr_enq act=%b/%b exp=0/1",
               bus.we, bus.hazard);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.we !== 1'b1 || bus.write_addr !== 5'd7
        || bus.write_data !== 64'hDEAD)
      $display("FAIL lr_commit act=%b/%0d/%h exp=1/7/dead",
               bus.we, bus.write_addr, bus.write_data);
    else pass_cnt++;
    total_cnt++;
    if (bus.pending[7] !== 1'b0 || bus.hazard !== 1'b0)
      $display("FAIL lr_pend_clr act=%b/%b exp=0/0",
               bus.pending[7], bus.hazard);
    else pass_cnt++;
  endtask

  task automatic test_starve();
    int first;
    first = -1;
    bus.wb_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (!m_stall()) begin
        bus.wb_rd   = 5'(k + 1);
        bus.wb_data = 64'(k) + 64'h100;
      end
      bus.lr_valid = (k < 2);
      bus.lr_rd    = 5'(20 + k);
      bus.lr_data  = 64'(k) + 64'hA00;
      #1;
      if (bus.wb_stall === 1'b1 && first < 0) first = k;
      total_cnt++;
      if (bus.lr_ready !== m_ready()
          || bus.wb_stall !== m_stall())
        $display("FAIL starve_hs k=%0d act=%b/%b exp=%b/%b",
                 k, bus.lr_ready, bus.wb_stall,
                 m_ready(), m_stall());
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus.we !== m_we || bus.write_addr !== m_addr
          || bus.write_data !== m_data)
        $display("FAIL starve_wr k=%0d act=%b/%0d/%h exp=%b/%0d/%h",
                 k, bus.we, bus.write_addr, bus.write_data,
                 m_we, m_addr, m_data);
      else pass_cnt++;
    end
    total_cnt++;
    if (first !== 5)
      $display("FAIL starve_first act=%0d exp=5", first);
    else pass_cnt++;
    idle();
    for (int k = 0; k < DEPTH + 1; k++) tick();
    total_cnt++;
    if (bus.lr_ready !== 1'b1 || bus.wb_stall !== 1'b0)
      $display("FAIL starve_drain act=%b/%b exp=1/0",
               bus.lr_ready, bus.wb_stall);
    else pass_cnt++;
  endtask

  task automatic test_x0();
    bus.wb_valid    = 1'b1;
    bus.wb_rd       = 5'd0;
    bus.wb_data     = 64'h55;
    bus.lr_valid    = 1'b1;
    bus.lr_rd       = 5'd0;
    bus.lr_data     = 64'h66;
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd0;
    for (int k = 0; k < 3; k++) begin
      tick();
      idle();
      total_cnt++;
      if (bus.we !== 1'b0 || bus.pending[0] !== 1'b0)
        $display("FAIL x0 k=%0d act=%b/%b exp=0/0",
                 k, bus.we, bus.pending[0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_set_clear();
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd9;
    tick();
    bus.issue_valid = 1'b0;
    bus.lr_valid = 1'b1;
    bus.lr_rd    = 5'd9;
    bus.lr_data  = 64'h99;
    tick();
    bus.lr_valid    = 1'b0;
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd9;
    tick();
    bus.issue_valid = 1'b0;
    total_cnt++;
    if (bus.we !== 1'b1 || bus.write_addr !== 5'd9
        || bus.write_data !== 64'h99)
      $display("FAIL setclr_wr act=%b/%0d/%h exp=1/9/99",
               bus.we, bus.write_addr, bus.write_data);
    else pass_cnt++;
    total_cnt++;
    if (bus.pending[9] !== 1'b1)
      $display("FAIL setclr_pend act=%b exp=1",
               bus.pending[9]);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (!m_stall()) begin
        bus.wb_valid = ($urandom_range(0, 99) < 55);
        bus.wb_rd    = 5'($urandom);
        bus.wb_data  = {$urandom, $urandom};
      end
      bus.lr_valid    = ($urandom_range(0, 99) < 45);
      bus.lr_rd       = 5'($urandom);
      bus.lr_data     = {$urandom, $urandom};
      bus.issue_valid = ($urandom_range(0, 99) < 40);
      bus.issue_rd    = 5'($urandom);
      bus.rs1         = 5'($urandom);
      bus.rs2         = 5'($urandom);
      #1;
      total_cnt++;
      if (bus.lr_ready !== m_ready()
          || bus.wb_stall !== m_stall()
          || bus.hazard !== m_hazard()
          || bus.pending !== m_pend)
        $display("FAIL rand_comb i=%0d act=%b/%b/%b/%h exp=%b/%b/%b/%h",
                 i, bus.lr_ready, bus.wb_stall, bus.hazard,
                 bus.pending, m_ready(), m_stall(),
                 m_hazard(), m_pend);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (bus.we !== m_we
          || (m_we && (bus.write_addr !== m_addr
                       || bus.write_data !== m_data)))
        $display("FAIL rand_wr i=%0d act=%b/%0d/%h exp=%b/%0d/%h",
                 i, bus.we, bus.write_addr, bus.write_data,
                 m_we, m_addr, m_data);
      else pass_cnt++;
    end
    idle();
  endtask

  task automatic test_async_reset();
    bus.wb_valid    = 1'b1;
    bus.wb_rd       = 5'd2;
    bus.wb_data     = 64'h22;
    bus.lr_valid    = 1'b1;
    bus.lr_rd       = 5'd3;
    bus.lr_data     = 64'h33;
    bus.issue_valid = 1'b1;
    bus.issue_rd    = 5'd3;
    tick();
    bus.wb_rd    = 5'd6;
    bus.lr_rd    = 5'd4;
    bus.issue_rd = 5'd4;
    tick();
    idle();
    total_cnt++;
    if (bus.lr_ready !== 1'b0 || bus.we !== 1'b1
        || bus.pending[4:3] !== 2'b11)
      $display("FAIL arst_pre act=%b/%b/%b exp=0/1/11",
               bus.lr_ready, bus.we, bus.pending[4:3]);
    else pass_cnt++;
    #3;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (bus.we !== 1'b0 || bus.write_addr !== 5'd0
        || bus.write_data !== 64'd0)
      $display("FAIL arst_wr act=%b/%0d/%h exp=0/0/0",
               bus.we, bus.write_addr, bus.write_data);
    else pass_cnt++;
    total_cnt++;
    if (bus.pending !== 32'd0 || bus.lr_ready !== 1'b1
        || bus.wb_stall !== 1'b0)
      $display("FAIL arst_state act=%h/%b/%b exp=0/1/0",
               bus.pending, bus.lr_ready, bus.wb_stall);
    else pass_cnt++;
    model_reset();
    #2;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total_cnt++;
      if (bus.we !== 1'b0 || bus.lr_ready !== 1'b1)
        $display("FAIL arst_post k=%0d act=%b/%b exp=0/1",
                 k, bus.we, bus.lr_ready);
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_single_wb();
    test_lr_basic();
    test_starve();
    test_x0();
    test_set_clear();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
